thread_scheduler: RTL and testbench

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler.sv | 125 ++++++++++++
 tb/tb_thread_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - round-robin barrel thread scheduler with per-thread block state and issue cooldown
module thread_scheduler #(
   parameter  int TH_ID_WIDTH = 2,
   parameter  int MIN_GAP     = 4,
   localparam int N           = 1 << TH_ID_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           th_enable,
   input  logic                   stall,
   input  logic [N-1:0]           block_set,
   input  logic [N-1:0]           block_clr,
   output logic                   issue_valid,
   output logic [TH_ID_WIDTH-1:0] issue_th_id,
   output logic [2*N-1:0]         th_state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READY   = 2'd1,
      ST_BLOCKED = 2'd2
   } th_state_t;

   // Cooldown reload: a thread issued on edge e may issue again on edge e+MIN_GAP.
   localparam logic [3:0] CD_LOAD = 4'(MIN_GAP - 1);

   th_state_t              r_state     [N];
   th_state_t              w_state_nxt [N];
   logic [3:0]             r_cd        [N];
   logic [TH_ID_WIDTH-1:0] r_ptr;
   logic [TH_ID_WIDTH-1:0] r_issue_id;
   logic                   r_issue_valid;
   logic [N-1:0]           w_elig;
   logic                   w_found;
   logic [TH_ID_WIDTH-1:0] w_sel;
   logic [TH_ID_WIDTH-1:0] w_idx;

   // Per-thread next state: disable dominates, set wins over clear, stall does not gate it.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_state_nxt[i] = r_state[i];
         if (!th_enable[i]) begin
            w_state_nxt[i] = ST_IDLE;
         end else begin
            case (r_state[i])
               ST_IDLE:    w_state_nxt[i] = ST_READY;
               ST_READY:   if (block_set[i]) w_state_nxt[i] = ST_BLOCKED;
               ST_BLOCKED: if (block_clr[i] && !block_set[i]) w_state_nxt[i] = ST_READY;
               default:    w_state_nxt[i] = ST_IDLE;
            endcase
         end
      end
   end

   // Per-thread state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) r_state[i] <= ST_IDLE;
      end else begin
         for (int i = 0; i < N; i++) r_state[i] <= w_state_nxt[i];
      end
   end

   // Eligibility: a same-cycle block_set masks the thread immediately.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < N; i++) begin
         w_elig[i] = (r_state[i] == ST_READY) && th_enable[i] && !block_set[i] && (r_cd[i] == 4'd0);
      end
   end

   // Round-robin pick: first eligible thread starting after the last issued one.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = r_ptr + TH_ID_WIDTH'(k);
         if (!w_found && w_elig[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   // Issue outputs and pointer; everything holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_valid <= 1'b0;
         r_issue_id    <= '0;
         r_ptr         <= '1;
      end else if (!stall) begin
         r_issue_valid <= w_found;
         if (w_found) begin
            r_issue_id <= w_sel;
            r_ptr      <= w_sel;
         end
      end
   end

   // Cooldown counters: reload on issue, count down otherwise, frozen during stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) r_cd[i] <= 4'd0;
      end else if (!stall) begin
         for (int i = 0; i < N; i++) begin
            if (w_found && (w_sel == TH_ID_WIDTH'(i))) begin
               r_cd[i] <= CD_LOAD;
            end else if (r_cd[i] != 4'd0) begin
               r_cd[i] <= r_cd[i] - 4'd1;
            end
         end
      end
   end

   assign issue_valid = r_issue_valid;
   assign issue_th_id = r_issue_id;

   // Pack per-thread states, thread i at bits [2i+1:2i].
   always_comb begin
      th_state = '0;
      for (int i = 0; i < N; i++) th_state[2*i +: 2] = r_state[i];
   end

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - self-checking bench for thread_scheduler (MIN_GAP=4 and MIN_GAP=1 instances)
module tb_thread_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] th_enable = 4'h0;
   logic       stall = 1'b0;
   logic [3:0] block_set = 4'h0;
   logic [3:0] block_clr = 4'h0;

   logic       v4, v1;
   logic [1:0] id4, id1;
   logic [7:0] st4, st1;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: per instance (0 -> MIN_GAP=4, 1 -> MIN_GAP=1)
   int m_state [2][4];
   int m_since [2][4];
   int m_ptr   [2];
   int m_valid [2];
   int m_id    [2];

   int exp36 [12] = '{0, 2, 3, 0, 2, 3, 0, 2, 3, 0, 1, 2};

   always #5 clk = ~clk;

   thread_scheduler #(.TH_ID_WIDTH(2), .MIN_GAP(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .th_enable(th_enable), .stall(stall),
      .block_set(block_set), .block_clr(block_clr),
      .issue_valid(v4), .issue_th_id(id4), .th_state(st4)
   );

   thread_scheduler #(.TH_ID_WIDTH(2), .MIN_GAP(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .th_enable(th_enable), .stall(stall),
      .block_set(block_set), .block_clr(block_clr),
      .issue_valid(v1), .issue_th_id(id1), .th_state(st1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int gap_of(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 4; i++) begin
            m_state[u][i] = 0;
            m_since[u][i] = 100;
         end
         m_ptr[u]   = 3;
         m_valid[u] = 0;
         m_id[u]    = 0;
      end
   endtask

   // One clock edge of the behavioural model, using inputs as seen at the edge.
   task automatic model_step();
      for (int u = 0; u < 2; u++) begin
         int elig [4];
         int sel;
         sel = -1;
         for (int i = 0; i < 4; i++)
            elig[i] = (m_state[u][i] == 1 && th_enable[i] && !block_set[i] &&
                       m_since[u][i] >= gap_of(u) - 1) ? 1 : 0;
         if (!stall) begin
            for (int k = 1; k <= 4; k++) begin
               int idx;
               idx = (m_ptr[u] + k) % 4;
               if (sel < 0 && elig[idx] == 1) sel = idx;
            end
            m_valid[u] = (sel >= 0) ? 1 : 0;
            if (sel >= 0) begin
               m_id[u]  = sel;
               m_ptr[u] = sel;
            end
            for (int i = 0; i < 4; i++)
               if (m_since[u][i] < 100) m_since[u][i]++;
            if (sel >= 0) m_since[u][sel] = 0;
         end
         for (int i = 0; i < 4; i++) begin
            if (!th_enable[i])                            m_state[u][i] = 0;
            else if (m_state[u][i] == 0)                  m_state[u][i] = 1;
            else if (m_state[u][i] == 1 && block_set[i])  m_state[u][i] = 2;
            else if (m_state[u][i] == 2 && block_clr[i] && !block_set[i]) m_state[u][i] = 1;
         end
      end
   endtask

   function automatic logic [7:0] model_state_vec(input int u);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[2*i +: 2] = 2'(m_state[u][i]);
      return r;
   endfunction

   // Advance the model on each edge.
   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Asynchronous reset clears the model immediately.
   always @(negedge rst_n) model_reset();

   // Compare both DUTs against the model every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("mdl_valid4", 32'(v4),  32'(m_valid[0]));
         check("mdl_id4",    32'(id4), 32'(m_id[0]));
         check("mdl_state4", 32'(st4), 32'(model_state_vec(0)));
         check("mdl_valid1", 32'(v1),  32'(m_valid[1]));
         check("mdl_id1",    32'(id1), 32'(m_id[1]));
         check("mdl_state1", 32'(st1), 32'(model_state_vec(1)));
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(v4), 32'd0);
      check("rst_id",    32'(id4), 32'd0);
      check("rst_state", 32'(st4), 32'd0);

      // All threads enabled: round-robin stream after one idle cycle
      rst_n = 1'b1;
      th_enable = 4'hF;
      @(negedge clk);
      check("rr_first_idle", 32'(v4), 32'd0);
      check("rr_all_ready", 32'(st4), 32'h55);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_valid4", 32'(v4), 32'd1);
         check("rr_id4", 32'(id4), 32'(k % 4));
         check("rr_id1", 32'(id1), 32'(k % 4));
      end

      // Stall for 3 cycles: outputs hold, then resume with the next thread
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_valid", 32'(v4), 32'd1);
         check("stall_id", 32'(id4), 32'd1);
      end
      stall = 1'b0;
      @(negedge clk);
      check("resume_id_a", 32'(id4), 32'd2);
      @(negedge clk);
      check("resume_id_b", 32'(id4), 32'd3);

      // Simultaneous set/clear on a READY thread: set wins
      block_set = 4'b0100;
      block_clr = 4'b0100;
      @(negedge clk);
      check("setclr_blocked4", 32'(st4[5:4]), 32'd2);
      check("setclr_blocked1", 32'(st1[5:4]), 32'd2);
      block_set = 4'b0000;
      @(negedge clk);
      check("clr_ready", 32'(st4[5:4]), 32'd1);
      block_clr = 4'b0000;

      // Disable beats block_set; re-enable returns to READY
      th_enable = 4'b0111;
      block_set = 4'b1000;
      @(negedge clk);
      check("disable_idle", 32'(st4[7:6]), 32'd0);
      block_set = 4'b0000;
      th_enable = 4'hF;
      @(negedge clk);
      check("reenable_ready", 32'(st4[7:6]), 32'd1);

      // Asynchronous reset between edges while issuing
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid4", 32'(v4), 32'd0);
      check("async_rst_valid1", 32'(v1), 32'd0);
      check("async_rst_id", 32'(id4), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", 32'(v4), 32'd0);
      @(negedge clk);
      check("post_rst_valid", 32'(v4), 32'd1);
      check("post_rst_id", 32'(id4), 32'd0);

      // Single thread: MIN_GAP=4 spaces issues, MIN_GAP=1 issues every cycle
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      th_enable = 4'b0001;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("gap_valid4", 32'(v4), (k % 4 == 0) ? 32'd1 : 32'd0);
         check("gap_id4", 32'(id4), 32'd0);
         check("gap_valid1", 32'(v1), 32'd1);
      end

      // Block thread 1 on cycle 3, unblock on cycle 10 (MIN_GAP=1 instance)
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      th_enable = 4'hF;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            check("blk_valid1", 32'(v1), 32'd1);
            check("blk_id1", 32'(id1), 32'(exp36[k-2]));
         end
         if (k == 3) check("blk_state1", 32'(st1[3:2]), 32'd2);
         block_set = (k == 2) ? 4'b0010 : 4'b0000;
         block_clr = (k == 9) ? 4'b0010 : 4'b0000;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
